bioz_sweep_sequencer: RTL and testbench
=======================================

// Module: bioz_sweep_sequencer
// PURPOSE
// Synthesizable sequencer for the BioZ EMG front end. On Start it resets the AFE, then sweeps
// excitation frequency (Fsel, descending) and electrode (Row/Col), settles, triggers averaged
// ADC conversions and emits one tagged impedance sample per (Fsel,Row,Col) point.
// Replaces hand-written stimulus timing; drives AFE/SigGen control pins and the ADC start handshake.
// PARAMETERS
// FSEL_START   10   first Fsel code of sweep (4-bit)
// FSEL_STOP    0    last Fsel code; must be <= FSEL_START
// NROWS        4    electrode rows scanned (1..4)
// NCOLS        4    electrode cols scanned (1..4)
// ADC_W        12   ADC result width
// AVG_LOG2     2    conversions averaged per point = 2**AVG_LOG2
// SETTLE_CYC   64   clk_ADC cycles waited after every Fsel/Row/Col change
// RST_CYC      4    cycles AFE Resetn held low at sweep start
// CONV_TIMEOUT 32   max cycles waiting for ADC_Done (ADC converts in 15)
// PORTS
// clk_ADC      in   1      sole clock, all logic posedge
// Reset        in   1      synchronous, active-high
// Start        in   1      pulse; begins sweep, honoured only in IDLE
// Abort        in   1      level; forces IDLE next cycle from any state
// ADC_Done     in   1      1-cycle pulse, ADC_Data valid same cycle
// ADC_Data     in   ADC_W  conversion result
// Fsel         out  4      SigGen frequency select
// Row, Col     out  2      electrode mux select
// Resetn       out  1      AFE/SigGen reset, active-low
// Clk_En       out  1      AFE clock enable
// ADC_En       out  1      ADC enable
// ADC_Start    out  1      1-cycle conversion start pulse
// Busy         out  1      high outside IDLE
// Sample_Valid out  1      1-cycle pulse: averaged point ready
// Sample_Data  out  ADC_W  averaged result
// Sample_Fsel/Sample_Row/Sample_Col  out 4/2/2  tag of Sample_Data
// Sweep_Done   out  1      1-cycle pulse at normal sweep completion
// Error        out  1      sticky ADC timeout; cleared by Reset or next accepted Start
// BEHAVIOUR
// Reset values: Fsel=FSEL_START, Row=Col=0, Resetn=1, Clk_En=0, ADC_En=0, ADC_Start=0, Busy=0,
//   Sample_*=0, Sweep_Done=0, Error=0, state IDLE, all counters 0.
// FSM: IDLE -> AFE_RST -> SETTLE -> CONV_START -> CONV_WAIT -> (CONV_START | POINT) -> NEXT -> SETTLE|DONE -> IDLE.
// IDLE: Clk_En=0, ADC_En=0. Start: clear Error, load Fsel=FSEL_START, Row=Col=0, go AFE_RST.
// AFE_RST: Resetn=0, Clk_En=1 for exactly RST_CYC cycles; then Resetn=1, ADC_En=1, go SETTLE.
// SETTLE: count SETTLE_CYC cycles, clear accumulator and conversion count.
// CONV_START: ADC_Start=1 for exactly one cycle; go CONV_WAIT, timeout counter=0.
// CONV_WAIT: on ADC_Done acc += ADC_Data (acc width ADC_W+AVG_LOG2, cannot overflow); count++;
//   if count==2**AVG_LOG2 go POINT else CONV_START. ADC_Done outside CONV_WAIT ignored.
//   No Done within CONV_TIMEOUT cycles -> Error=1, go DONE without Sweep_Done pulse.
// POINT: one cycle; Sample_Data = acc >> AVG_LOG2 (truncate), tags = current Fsel/Row/Col, Sample_Valid=1.
// NEXT: Col++; at NCOLS-1 wrap Col=0, Row++; at NROWS-1 wrap Row=0, Fsel--; after point
//   (FSEL_STOP,NROWS-1,NCOLS-1) go DONE. Fsel never decrements below FSEL_STOP (no 4-bit wrap).
// DONE: Sweep_Done=1 for one cycle (only if Error=0), ADC_En=0, Clk_En=0, go IDLE.
// Abort (priority over all but Reset): next cycle IDLE, ADC_Start=0, Resetn=1, no Sample_Valid or
//   Sweep_Done from partial point; Fsel/Row/Col hold last values. Start concurrent with Abort ignored.
// Start while Busy ignored. Reset mid-sweep: all outputs to reset values next edge.
// Per-point latency from NEXT: 1+SETTLE_CYC + 2**AVG_LOG2*(1+conv latency) + 1 cycles.
// Total points = (FSEL_START-FSEL_STOP+1)*NROWS*NCOLS.
// TESTING
// Default params, ADC model Done 15 cycles after Start, Data=0x400 -> 176 Sample_Valid, all 0x400,
//   tags from (10,0,0) to (0,3,3) in Col-Row-Fsel order, then one Sweep_Done.
// AVG_LOG2=2, Data sequence 1,2,3,6 -> Sample_Data=3; Data all 0xFFF -> 0xFFF (no overflow).
// Start -> Resetn low exactly 4 cycles, first ADC_Start exactly 64 cycles after Resetn rises.
// ADC model never asserts Done -> Error=1 after 32 cycles in CONV_WAIT, no Sweep_Done, Busy=0,
//   next Start clears Error.
// Abort asserted in CONV_WAIT of point (7,2,1) -> IDLE next cycle, no Sample_Valid, Start while Busy ignored.
// FSEL_START=FSEL_STOP=3, NROWS=NCOLS=1 -> exactly one sample tagged (3,0,0) then Sweep_Done.

Source files
------------

// File: rtl/bioz_sweep_sequencer_if.sv
// Control/data bundle between the BioZ sweep sequencer and the AFE, SigGen, ADC and sample consumer.
// The master modport is the sequencer; the slave modport is whatever drives Start/Abort and the ADC.
interface bioz_sweep_sequencer_if #(
    parameter int ADC_W = 12
) ();
    logic             Start;
    logic             Abort;
    logic             ADC_Done;
    logic [ADC_W-1:0] ADC_Data;

    logic [3:0]       Fsel;
    logic [1:0]       Row;
    logic [1:0]       Col;
    logic             Resetn;
    logic             Clk_En;
    logic             ADC_En;
    logic             ADC_Start;
    logic             Busy;
    logic             Sample_Valid;
    logic [ADC_W-1:0] Sample_Data;
    logic [3:0]       Sample_Fsel;
    logic [1:0]       Sample_Row;
    logic [1:0]       Sample_Col;
    logic             Sweep_Done;
    logic             Error;

    modport master (
        input  Start, Abort, ADC_Done, ADC_Data,
        output Fsel, Row, Col, Resetn, Clk_En, ADC_En, ADC_Start, Busy,
               Sample_Valid, Sample_Data, Sample_Fsel, Sample_Row, Sample_Col,
               Sweep_Done, Error
    );

    modport slave (
        output Start, Abort, ADC_Done, ADC_Data,
        input  Fsel, Row, Col, Resetn, Clk_En, ADC_En, ADC_Start, Busy,
               Sample_Valid, Sample_Data, Sample_Fsel, Sample_Row, Sample_Col,
               Sweep_Done, Error
    );
endinterface

// File: rtl/bioz_sweep_sequencer.sv
// BioZ sweep sequencer: resets the AFE, then walks Fsel (descending) x Row x Col, settling and
// averaging 2**AVG_LOG2 ADC conversions per point and emitting one tagged sample per point.
module bioz_sweep_sequencer #(
    parameter int FSEL_START   = 10,
    parameter int FSEL_STOP    = 0,
    parameter int NROWS        = 4,
    parameter int NCOLS        = 4,
    parameter int ADC_W        = 12,
    parameter int AVG_LOG2     = 2,
    parameter int SETTLE_CYC   = 64,
    parameter int RST_CYC      = 4,
    parameter int CONV_TIMEOUT = 32
) (
    input  logic                   clk_ADC,
    input  logic                   Reset,
    bioz_sweep_sequencer_if.master bus
);

    localparam int CONV_N    = 1 << AVG_LOG2;
    localparam int ACC_W     = ADC_W + AVG_LOG2;
    localparam int CC_W      = AVG_LOG2 + 1;
    localparam int CNT_MAX_A = (SETTLE_CYC > RST_CYC) ? SETTLE_CYC : RST_CYC;
    localparam int CNT_MAX   = (CNT_MAX_A > CONV_TIMEOUT) ? CNT_MAX_A : CONV_TIMEOUT;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_AFE_RST,
        S_SETTLE,
        S_CONV_START,
        S_CONV_WAIT,
        S_POINT,
        S_NEXT,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [CC_W-1:0]    r_conv_cnt;
    logic [ACC_W-1:0]   r_acc;
    logic [3:0]         r_fsel;
    logic [1:0]         r_row;
    logic [1:0]         r_col;
    logic               r_error;
    logic [ADC_W-1:0]   r_sample_data;
    logic [3:0]         r_sample_fsel;
    logic [1:0]         r_sample_row;
    logic [1:0]         r_sample_col;

    logic [ACC_W-1:0]   w_acc_sum;
    logic               w_conv_last;
    logic               w_last_point;

    assign w_acc_sum    = r_acc + ACC_W'(bus.ADC_Data);
    assign w_conv_last  = (r_conv_cnt == CC_W'(CONV_N - 1));
    assign w_last_point = (r_fsel == 4'(FSEL_STOP)) && (r_row == 2'(NROWS - 1))
                          && (r_col == 2'(NCOLS - 1));

    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_ADC) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        w_state_next = r_state;
        if (bus.Abort) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:       if (bus.Start) w_state_next = S_AFE_RST;
                S_AFE_RST:    if (r_cnt == CNT_W'(RST_CYC - 1)) w_state_next = S_SETTLE;
                S_SETTLE:     if (r_cnt == CNT_W'(SETTLE_CYC - 1)) w_state_next = S_CONV_START;
                S_CONV_START: w_state_next = S_CONV_WAIT;
                S_CONV_WAIT: begin
                    if (bus.ADC_Done) begin
                        w_state_next = w_conv_last ? S_POINT : S_CONV_START;
                    end else if (r_cnt == CNT_W'(CONV_TIMEOUT - 1)) begin
                        w_state_next = S_DONE;
                    end
                end
                S_POINT:      w_state_next = S_NEXT;
                S_NEXT:       w_state_next = w_last_point ? S_DONE : S_SETTLE;
                S_DONE:       w_state_next = S_IDLE;
                default:      w_state_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.Resetn       = 1'b1;
        bus.Clk_En       = 1'b0;
        bus.ADC_En       = 1'b0;
        bus.ADC_Start    = 1'b0;
        bus.Busy         = 1'b1;
        bus.Sample_Valid = 1'b0;
        bus.Sweep_Done   = 1'b0;
        case (r_state)
            S_IDLE:    bus.Busy = 1'b0;
            S_AFE_RST: begin
                bus.Resetn = 1'b0;
                bus.Clk_En = 1'b1;
            end
            S_SETTLE, S_CONV_WAIT, S_NEXT: begin
                bus.Clk_En = 1'b1;
                bus.ADC_En = 1'b1;
            end
            S_CONV_START: begin
                bus.Clk_En    = 1'b1;
                bus.ADC_En    = 1'b1;
                bus.ADC_Start = 1'b1;
            end
            S_POINT: begin
                bus.Clk_En       = 1'b1;
                bus.ADC_En       = 1'b1;
                bus.Sample_Valid = 1'b1;
            end
            S_DONE:    bus.Sweep_Done = ~r_error;
            default:   bus.Busy = 1'b1;
        endcase
    end

    // One shared cycle counter; it restarts on every state change and idles at zero.
    always_ff @(posedge clk_ADC) begin
        if (Reset) begin
            r_cnt <= '0;
        end else if ((w_state_next != r_state) || (r_state == S_IDLE)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_ADC) begin
        if (Reset) begin
            r_conv_cnt    <= '0;
            r_acc         <= '0;
            r_fsel        <= 4'(FSEL_START);
            r_row         <= '0;
            r_col         <= '0;
            r_error       <= 1'b0;
            r_sample_data <= '0;
            r_sample_fsel <= '0;
            r_sample_row  <= '0;
            r_sample_col  <= '0;
        end else begin
            if ((r_state == S_IDLE) && (w_state_next == S_AFE_RST)) begin
                r_error <= 1'b0;
                r_fsel  <= 4'(FSEL_START);
                r_row   <= '0;
                r_col   <= '0;
            end
            if (r_state == S_SETTLE) begin
                r_acc      <= '0;
                r_conv_cnt <= '0;
            end
            if ((r_state == S_CONV_WAIT) && bus.ADC_Done && !bus.Abort) begin
                r_acc      <= w_acc_sum;
                r_conv_cnt <= r_conv_cnt + 1'b1;
            end
            // Sample is captured with the final conversion folded in, so it is stable during POINT.
            if ((r_state == S_CONV_WAIT) && (w_state_next == S_POINT)) begin
                r_sample_data <= ADC_W'(w_acc_sum >> AVG_LOG2);
                r_sample_fsel <= r_fsel;
                r_sample_row  <= r_row;
                r_sample_col  <= r_col;
            end
            if ((r_state == S_CONV_WAIT) && (w_state_next == S_DONE)) begin
                r_error <= 1'b1;
            end
            if ((r_state == S_NEXT) && (w_state_next == S_SETTLE)) begin
                if (r_col == 2'(NCOLS - 1)) begin
                    r_col <= '0;
                    if (r_row == 2'(NROWS - 1)) begin
                        r_row <= '0;
                        if (r_fsel != 4'(FSEL_STOP)) r_fsel <= r_fsel - 1'b1;
                    end else begin
                        r_row <= r_row + 1'b1;
                    end
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
        end
    end

    assign bus.Fsel        = r_fsel;
    assign bus.Row         = r_row;
    assign bus.Col         = r_col;
    assign bus.Error       = r_error;
    assign bus.Sample_Data = r_sample_data;
    assign bus.Sample_Fsel = r_sample_fsel;
    assign bus.Sample_Row  = r_sample_row;
    assign bus.Sample_Col  = r_sample_col;

endmodule

// File: tb/tb_bioz_sweep_sequencer.sv
// Scoreboard bench for bioz_sweep_sequencer: a default-parameter instance for the full sweep,
// averaging, timing, timeout and abort scenarios, and a one-point instance for the degenerate sweep.
module tb_bioz_sweep_sequencer;

    typedef struct packed {
        logic [11:0] data;
        logic [3:0]  fsel;
        logic [1:0]  row;
        logic [1:0]  col;
    } sample_t;

    logic        clk = 1'b0;
    logic        rst;
    int          checks = 0;
    int          errors = 0;
    sample_t     exp_q[$];
    logic [11:0] adc_q_a[$];
    logic [11:0] adc_const_a = 12'h400;
    bit          adc_respond_a = 1'b1;
    int          adc_cnt_a = 0;
    int          adc_cnt_b = 0;

    always #5 clk = ~clk;

    bioz_sweep_sequencer_if #(.ADC_W(12)) bus_a ();
    bioz_sweep_sequencer_if #(.ADC_W(12)) bus_b ();

    bioz_sweep_sequencer u_dut_a (
        .clk_ADC (clk),
        .Reset   (rst),
        .bus     (bus_a)
    );

    bioz_sweep_sequencer #(
        .FSEL_START (3),
        .FSEL_STOP  (3),
        .NROWS      (1),
        .NCOLS      (1)
    ) u_dut_b (
        .clk_ADC (clk),
        .Reset   (rst),
        .bus     (bus_b)
    );

    // ADC models: Done pulses 15 cycles after the cycle in which ADC_Start is seen high.
    always @(posedge clk) begin
        #1;
        bus_a.ADC_Done = 1'b0;
        if (adc_cnt_a > 0) begin
            adc_cnt_a = adc_cnt_a - 1;
            if (adc_cnt_a == 0 && adc_respond_a) begin
                bus_a.ADC_Done = 1'b1;
                if (adc_q_a.size() > 0) bus_a.ADC_Data = adc_q_a.pop_front();
                else                    bus_a.ADC_Data = adc_const_a;
            end
        end
        if (bus_a.ADC_Start === 1'b1) adc_cnt_a = 15;
    end

    always @(posedge clk) begin
        #1;
        bus_b.ADC_Done = 1'b0;
        bus_b.ADC_Data = 12'h123;
        if (adc_cnt_b > 0) begin
            adc_cnt_b = adc_cnt_b - 1;
            if (adc_cnt_b == 0) bus_b.ADC_Done = 1'b1;
        end
        if (bus_b.ADC_Start === 1'b1) adc_cnt_b = 15;
    end

    function automatic sample_t got_a();
        return sample_t'({bus_a.Sample_Data, bus_a.Sample_Fsel, bus_a.Sample_Row, bus_a.Sample_Col});
    endfunction

    function automatic sample_t got_b();
        return sample_t'({bus_b.Sample_Data, bus_b.Sample_Fsel, bus_b.Sample_Row, bus_b.Sample_Col});
    endfunction

    // {Resetn, Clk_En, ADC_En, ADC_Start, Busy, Sample_Valid, Sweep_Done, Error}
    function automatic logic [7:0] ctrl_a();
        return {bus_a.Resetn, bus_a.Clk_En, bus_a.ADC_En, bus_a.ADC_Start,
                bus_a.Busy, bus_a.Sample_Valid, bus_a.Sweep_Done, bus_a.Error};
    endfunction

    function automatic logic [7:0] pos_a();
        return {bus_a.Fsel, bus_a.Row, bus_a.Col};
    endfunction

    task automatic pulse_start_a();
        @(posedge clk); #1 bus_a.Start = 1'b1;
        @(posedge clk); #1 bus_a.Start = 1'b0;
    endtask

    task automatic abort_and_flush_a();
        @(posedge clk); #1 bus_a.Abort = 1'b1;
        @(posedge clk); #1 bus_a.Abort = 1'b0;
        repeat (20) @(posedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (ctrl_a() !== 8'b1000_0000) begin
            errors++; $display("FAIL reset_ctrl got %b expected %b", ctrl_a(), 8'b1000_0000);
        end
        checks++;
        if (pos_a() !== {4'd10, 2'd0, 2'd0}) begin
            errors++; $display("FAIL reset_pos got %h expected %h", pos_a(), {4'd10, 2'd0, 2'd0});
        end
        checks++;
        if (got_a() !== '0) begin
            errors++; $display("FAIL reset_sample got %h expected 0", got_a());
        end
        checks++;
        if ({bus_b.Fsel, bus_b.Busy} !== {4'd3, 1'b0}) begin
            errors++; $display("FAIL reset_b got %h expected %h", {bus_b.Fsel, bus_b.Busy}, {4'd3, 1'b0});
        end
    endtask

    task automatic test_start_timing();
        int n_low = 0;
        int k = 0;
        bit found = 1'b0;
        pulse_start_a();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus_a.Resetn === 1'b0) n_low++;
            else break;
        end
        checks++;
        if (n_low != 4) begin
            errors++; $display("FAIL resetn_low_cycles got %0d expected 4", n_low);
        end
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            k++;
            if (bus_a.ADC_Start === 1'b1) begin found = 1'b1; break; end
        end
        checks++;
        if (!found || k != 64) begin
            errors++; $display("FAIL first_adc_start_delay got %0d expected 64 (found=%0d)", k, found);
        end
        abort_and_flush_a();
    endtask

    task automatic test_full_sweep();
        int n_samp = 0;
        int n_done = 0;
        bit done_seen = 1'b0;
        int q_at_done = -1;
        sample_t e;
        adc_const_a = 12'h400;
        for (int f = 10; f >= 0; f--)
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    exp_q.push_back(sample_t'({12'h400, 4'(f), 2'(r), 2'(c)}));
        pulse_start_a();
        for (int i = 0; i < 30000 && !done_seen; i++) begin
            @(negedge clk);
            if (bus_a.Sample_Valid === 1'b1) begin
                n_samp++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL sweep_extra_sample got %h expected none", got_a());
                end else begin
                    e = exp_q.pop_front();
                    if (got_a() !== e) begin
                        errors++; $display("FAIL sweep_sample got %h expected %h", got_a(), e);
                    end
                end
            end
            if (bus_a.Sweep_Done === 1'b1) begin
                n_done++; done_seen = 1'b1; q_at_done = exp_q.size();
            end
        end
        repeat (10) begin
            @(negedge clk);
            if (bus_a.Sweep_Done === 1'b1) n_done++;
        end
        checks++;
        if (n_samp != 176 || q_at_done != 0) begin
            errors++; $display("FAIL sweep_count got %0d (left %0d) expected 176 (left 0)", n_samp, q_at_done);
        end
        checks++;
        if (n_done != 1) begin
            errors++; $display("FAIL sweep_done_pulses got %0d expected 1", n_done);
        end
        checks++;
        if (ctrl_a() !== 8'b1000_0000 || pos_a() !== {4'd0, 2'd3, 2'd3}) begin
            errors++; $display("FAIL sweep_end_state got %b/%h expected %b/%h",
                               ctrl_a(), pos_a(), 8'b1000_0000, {4'd0, 2'd3, 2'd3});
        end
        exp_q.delete();
    endtask

    task automatic test_averaging();
        logic [11:0] data [12] = '{12'd1, 12'd2, 12'd3, 12'd6,
                                   12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF,
                                   12'd7, 12'd0, 12'd0, 12'd0};
        int n_samp = 0;
        sample_t e;
        foreach (data[i]) adc_q_a.push_back(data[i]);
        exp_q.push_back(sample_t'({12'd3,   4'd10, 2'd0, 2'd0}));
        exp_q.push_back(sample_t'({12'hFFF, 4'd10, 2'd0, 2'd1}));
        exp_q.push_back(sample_t'({12'd1,   4'd10, 2'd0, 2'd2}));
        pulse_start_a();
        for (int i = 0; i < 1500 && n_samp < 3; i++) begin
            @(negedge clk);
            if (bus_a.Sample_Valid === 1'b1) begin
                n_samp++;
                e = exp_q.pop_front();
                checks++;
                if (got_a() !== e) begin
                    errors++; $display("FAIL avg_sample got %h expected %h", got_a(), e);
                end
            end
        end
        checks++;
        if (n_samp != 3) begin
            errors++; $display("FAIL avg_sample_count got %0d expected 3", n_samp);
        end
        abort_and_flush_a();
        exp_q.delete();
        adc_q_a.delete();
    endtask

    task automatic test_timeout();
        bit found = 1'b0;
        int n = 0;
        int n_sd = 0;
        adc_respond_a = 1'b0;
        pulse_start_a();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus_a.ADC_Start === 1'b1) begin found = 1'b1; break; end
        end
        for (int i = 0; i < 100 && found; i++) begin
            @(negedge clk);
            n++;
            if (bus_a.Sweep_Done === 1'b1) n_sd++;
            if (bus_a.Error === 1'b1) break;
        end
        checks++;
        if (!found || n != 33) begin
            errors++; $display("FAIL timeout_error_delay got %0d expected 33 (found=%0d)", n, found);
        end
        repeat (10) begin
            @(negedge clk);
            if (bus_a.Sweep_Done === 1'b1) n_sd++;
        end
        checks++;
        if (n_sd != 0 || bus_a.Busy !== 1'b0 || bus_a.Error !== 1'b1) begin
            errors++; $display("FAIL timeout_end got sd=%0d busy=%b err=%b expected sd=0 busy=0 err=1",
                               n_sd, bus_a.Busy, bus_a.Error);
        end
        adc_respond_a = 1'b1;
        pulse_start_a();
        @(negedge clk);
        checks++;
        if (bus_a.Error !== 1'b0 || bus_a.Busy !== 1'b1) begin
            errors++; $display("FAIL timeout_restart got err=%b busy=%b expected err=0 busy=1",
                               bus_a.Error, bus_a.Busy);
        end
        abort_and_flush_a();
    endtask

    task automatic test_abort();
        int n_samp = 0;
        int n_quiet = 0;
        bit bs_done = 1'b0;
        bit bs_pending = 1'b0;
        bit hit = 1'b0;
        sample_t last = '0;
        adc_const_a = 12'h400;
        pulse_start_a();
        for (int i = 0; i < 9000 && !hit; i++) begin
            @(negedge clk);
            if (bus_a.Sample_Valid === 1'b1) begin n_samp++; last = got_a(); end
            if (bs_pending) begin
                bus_a.Start = 1'b0;
                bs_pending = 1'b0;
                checks++;
                if (bus_a.Resetn !== 1'b1 || bus_a.Col !== 2'd2) begin
                    errors++; $display("FAIL start_while_busy got resetn=%b col=%0d expected resetn=1 col=2",
                                       bus_a.Resetn, bus_a.Col);
                end
            end else if (!bs_done && bus_a.Col === 2'd2 && bus_a.Busy === 1'b1) begin
                bus_a.Start = 1'b1;
                bs_done = 1'b1;
                bs_pending = 1'b1;
            end
            if (bus_a.ADC_Start === 1'b1 && pos_a() === {4'd7, 2'd2, 2'd1}) begin
                hit = 1'b1;
                @(negedge clk);
                bus_a.Abort = 1'b1;
                @(negedge clk);
                bus_a.Abort = 1'b0;
            end
        end
        checks++;
        if (!hit || ctrl_a() !== 8'b1000_0000) begin
            errors++; $display("FAIL abort_ctrl got %b expected %b (hit=%0d)", ctrl_a(), 8'b1000_0000, hit);
        end
        checks++;
        if (pos_a() !== {4'd7, 2'd2, 2'd1}) begin
            errors++; $display("FAIL abort_pos_hold got %h expected %h", pos_a(), {4'd7, 2'd2, 2'd1});
        end
        checks++;
        if (n_samp != 57 || last !== sample_t'({12'h400, 4'd7, 2'd2, 2'd0})) begin
            errors++; $display("FAIL abort_prior_samples got %0d last %h expected 57 last %h",
                               n_samp, last, sample_t'({12'h400, 4'd7, 2'd2, 2'd0}));
        end
        repeat (40) begin
            @(negedge clk);
            if (bus_a.Sample_Valid === 1'b1 || bus_a.Sweep_Done === 1'b1 || bus_a.Busy === 1'b1) n_quiet++;
        end
        checks++;
        if (n_quiet != 0) begin
            errors++; $display("FAIL abort_quiet got %0d active cycles expected 0", n_quiet);
        end
        bus_a.Start = 1'b1;
        bus_a.Abort = 1'b1;
        @(negedge clk);
        bus_a.Start = 1'b0;
        bus_a.Abort = 1'b0;
        @(negedge clk);
        checks++;
        if (bus_a.Busy !== 1'b0 || bus_a.Resetn !== 1'b1) begin
            errors++; $display("FAIL start_with_abort got busy=%b resetn=%b expected busy=0 resetn=1",
                               bus_a.Busy, bus_a.Resetn);
        end
    endtask

    task automatic test_reset_midsweep();
        bit seen = 1'b0;
        bit reached = 1'b0;
        pulse_start_a();
        for (int i = 0; i < 600 && !reached; i++) begin
            @(negedge clk);
            if (bus_a.Sample_Valid === 1'b1) seen = 1'b1;
            if (seen && bus_a.Col === 2'd1) reached = 1'b1;
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (!reached || ctrl_a() !== 8'b1000_0000 || pos_a() !== {4'd10, 2'd0, 2'd0}) begin
            errors++; $display("FAIL reset_midsweep got %b/%h expected %b/%h (reached=%0d)",
                               ctrl_a(), pos_a(), 8'b1000_0000, {4'd10, 2'd0, 2'd0}, reached);
        end
        checks++;
        if (got_a() !== '0) begin
            errors++; $display("FAIL reset_midsweep_sample got %h expected 0", got_a());
        end
        rst = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_single_point();
        int n_samp = 0;
        int n_done = 0;
        bit order_bad = 1'b0;
        sample_t e;
        exp_q.push_back(sample_t'({12'h123, 4'd3, 2'd0, 2'd0}));
        @(posedge clk); #1 bus_b.Start = 1'b1;
        @(posedge clk); #1 bus_b.Start = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (bus_b.Sample_Valid === 1'b1) begin
                n_samp++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL single_extra_sample got %h expected none", got_b());
                end else begin
                    e = exp_q.pop_front();
                    if (got_b() !== e) begin
                        errors++; $display("FAIL single_sample got %h expected %h", got_b(), e);
                    end
                end
            end
            if (bus_b.Sweep_Done === 1'b1) begin
                n_done++;
                if (n_samp == 0) order_bad = 1'b1;
            end
        end
        checks++;
        if (n_samp != 1 || n_done != 1 || order_bad) begin
            errors++; $display("FAIL single_counts got samples=%0d done=%0d order_bad=%0d expected 1 1 0",
                               n_samp, n_done, order_bad);
        end
        checks++;
        if (bus_b.Busy !== 1'b0 || bus_b.Error !== 1'b0) begin
            errors++; $display("FAIL single_end got busy=%b err=%b expected 0 0", bus_b.Busy, bus_b.Error);
        end
        exp_q.delete();
    endtask

    initial begin
        rst         = 1'b1;
        bus_a.Start = 1'b0;
        bus_a.Abort = 1'b0;
        bus_b.Start = 1'b0;
        bus_b.Abort = 1'b0;
        test_reset();
        test_start_timing();
        test_full_sweep();
        test_averaging();
        test_timeout();
        test_abort();
        test_reset_midsweep();
        test_single_point();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
